instr_issue_queue: RTL and testbench

Buffers 8-bit instructions from a loader and issues them one at a time onto the `instruction` input of `cpu_top`. It sits directly upstream of `cpu_top`. It holds each instruction stable until the CPU signals completion on `done`, then inserts a one-cycle NOP gap before issuing the next instruction. A watchdog drops any instruction whose completion never arrives.

---
 rtl/instr_issue_queue.sv | 120 ++++++++++++
 tb/tb_instr_issue_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// Instruction issue queue sitting in front of cpu_top.
// Loader pushes 8-bit instructions into a circular FIFO. The issuer drives one
// instruction at a time and holds it until the CPU reports completion. After a
// completion it drives NOP for at least one cycle before the next issue. A
// watchdog drops an instruction whose completion never arrives and sets a
// sticky error flag.
//
// state | meaning
// IDLE  | nothing in flight, instruction = NOP, issue head if FIFO non-empty
// WAIT  | instruction held on the CPU, waiting for done edge or watchdog expiry
module instr_issue_queue #(
  parameter int         DEPTH   = 8,
  parameter logic [7:0] NOP     = 8'h00,
  parameter int         TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] instruction,
  input  logic       cpu_done,
  output logic       busy,
  output logic       empty,
  output logic       full,
  output logic [7:0] issued_count,
  output logic       timeout_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, WAIT} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    wd;
  logic          done_q;
  state_t        state;

  logic push;
  logic pop;
  logic done_edge;

  // Handshake, pop and completion-edge decode; flags come from registered state.
  always_comb begin
    full      = (count == CW'(DEPTH));
    empty     = (count == '0);
    in_ready  = !full;
    push      = in_valid && in_ready;
    pop       = (state == IDLE) && !empty;
    done_edge = cpu_done && !done_q;
    busy      = (state == WAIT);
  end

  // Storage array; contents are don't-care after reset since pointers restart.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Issue FSM with watchdog; done edge takes priority over a coincident timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      instruction  <= NOP;
      wd           <= '0;
      done_q       <= 1'b0;
      issued_count <= '0;
      timeout_err  <= 1'b0;
    end else begin
      done_q <= cpu_done;
      case (state)
        IDLE: begin
          if (!empty) begin
            instruction <= mem[rd_ptr];
            wd          <= '0;
            state       <= WAIT;
          end else begin
            instruction <= NOP;
          end
        end
        WAIT: begin
          if (done_edge) begin
            instruction  <= NOP;
            issued_count <= issued_count + 8'd1;
            state        <= IDLE;
          end else if (wd == 8'(TIMEOUT - 1)) begin
            instruction <= NOP;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        default: begin
          instruction <= NOP;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue: scoreboard of pushed instructions is
// compared against each instruction the queue issues.
module tb_instr_issue_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] instruction;
  logic       cpu_done;
  logic       busy;
  logic       empty;
  logic       full;
  logic [7:0] issued_count;
  logic       timeout_err;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_issued = 8'd0;

  instr_issue_queue #(.DEPTH(8), .NOP(8'h00), .TIMEOUT(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .instruction  (instruction),
    .cpu_done     (cpu_done),
    .busy         (busy),
    .empty        (empty),
    .full         (full),
    .issued_count (issued_count),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input bit acc);
    chk("in_ready_before_push", in_ready, acc);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    if (acc) sb.push_back(d);
  endtask

  task automatic expect_issue();
    int n = 0;
    logic [7:0] e;
    while (!busy && n < 200) begin
      step();
      n++;
    end
    chk("issue_wait", busy, 1);
    e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    chk("issue_order", instruction, e);
  endtask

  task automatic complete();
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    exp_issued = exp_issued + 8'd1;
    chk("done_nop", instruction, 8'h00);
    chk("done_busy", busy, 0);
    chk("done_count", issued_count, exp_issued);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    cpu_done = 1'b0;
    step();
    step();
    chk("rst_instruction", instruction, 8'h00);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_issued", issued_count, 0);
    chk("rst_timeout", timeout_err, 0);
    reset = 1'b0;
    step();

    // Basic issue, completion, one-cycle NOP gap.
    push(8'h34, 1);
    chk("first_push_not_yet_issued", instruction, 8'h00);
    chk("first_push_not_empty", empty, 0);
    push(8'h78, 1);
    chk("issue_one_cycle_after_push", busy, 1);
    expect_issue();
    complete();
    step();
    chk("gap_one_cycle", busy, 1);
    expect_issue();

    // Held done counts once.
    cpu_done = 1'b1;
    repeat (10) step();
    cpu_done = 1'b0;
    exp_issued = exp_issued + 8'd1;
    chk("held_done_count", issued_count, exp_issued);
    chk("held_done_busy", busy, 0);
    step();
    chk("held_done_count_after", issued_count, exp_issued);

    // Done while idle is ignored.
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    step();
    chk("idle_done_ignored", issued_count, exp_issued);

    // Fill: 9 pushes, one issued and eight queued.
    for (int i = 0; i < 9; i++) push(8'hA1 + 8'(i), 1);
    chk("full_set", full, 1);
    chk("full_in_ready", in_ready, 0);
    push(8'hEE, 0);
    chk("full_hold", full, 1);
    expect_issue();
    complete();
    chk("full_after_done", in_ready, 0);
    step();
    chk("ready_returns", in_ready, 1);
    chk("full_clear", full, 0);
    expect_issue();
    complete();
    for (int i = 0; i < 7; i++) begin
      expect_issue();
      complete();
    end
    step();
    chk("drained_empty", empty, 1);

    // Watchdog drop and next issue.
    push(8'hAB, 1);
    push(8'hCD, 1);
    expect_issue();
    repeat (63) step();
    chk("wd_hold_instr", instruction, 8'hAB);
    chk("wd_hold_err", timeout_err, 0);
    step();
    chk("wd_drop_instr", instruction, 8'h00);
    chk("wd_drop_err", timeout_err, 1);
    chk("wd_drop_busy", busy, 0);
    chk("wd_drop_count", issued_count, exp_issued);
    step();
    chk("wd_next_issue", busy, 1);
    expect_issue();
    complete();
    chk("wd_err_sticky", timeout_err, 1);

    // Reset mid-operation with entries queued; push during reset is dropped.
    push(8'h78, 1);
    push(8'h11, 1);
    push(8'h22, 1);
    push(8'h33, 1);
    expect_issue();
    chk("pre_rst_queued", empty, 0);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    exp_issued = 8'd0;
    chk("mid_rst_instr", instruction, 8'h00);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_issued", issued_count, 0);
    chk("mid_rst_err", timeout_err, 0);
    chk("mid_rst_ready", in_ready, 1);
    repeat (3) step();
    chk("post_rst_quiet", busy, 0);
    chk("post_rst_instr", instruction, 8'h00);

    // 256 completions wrap the counter.
    for (int i = 0; i < 256; i++) begin
      push(8'((i % 250) + 1), 1);
      expect_issue();
      complete();
      if (i == 254) chk("count_255", issued_count, 8'd255);
    end
    chk("count_wrap", issued_count, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
